regfile_table_loader: RTL and testbench
=======================================

# regfile_table_loader

Runtime loader for the LUT-RAM multi-ported register files, which are otherwise initialised only at elaboration from a memory file. It accepts a load or fill command, assembles narrow streamed chunks into full `data_width` entries, and drives the register file's single write port (`ADDR_IN`/`D_IN`/`WE`) one entry at a time. It sits between the configuration path (host or config packet decoder) and a routing/lookup table instance, so tables can be reprogrammed without re-synthesis.

## Interface
- `data_width`, 1, width of one register-file entry.
- `addr_width`, 1, register-file address width.
- `depth`, `1<<addr_width`, number of entries; addresses wrap modulo `depth`.
- `chunk_width`, 8, width of one streamed input chunk.

Ports:
- `CLK`  in  1  sole clock; everything is synchronous to its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_op`  in  2  0 = LOAD (stream entries), 1 = FILL (constant); 2 and 3 are treated as FILL.
- `cmd_base`  in  `addr_width`  first address written.
- `cmd_count`  in  `addr_width+1`  number of entries; values above `depth` saturate to `depth`.
- `cmd_fill`  in  `data_width`  FILL value.
- `in_valid`  in  1  chunk offered.
- `in_ready`  out  1  chunk accepted when high together with `in_valid`.
- `in_data`  in  `chunk_width`  chunk, LSB-first within an entry.
- `ADDR_IN`  out  `addr_width`  register-file write address (registered).
- `D_IN`  out  `data_width`  register-file write data (registered).
- `WE`  out  1  register-file write enable (registered).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- `NCH = ceil(data_width/chunk_width)` chunks make one entry. Chunk k fills bits `[k*chunk_width +: chunk_width]`; bits of the last chunk above `data_width` are dropped.
- FSM states: IDLE, COLLECT, WRITE, FILL, DONE.
- **IDLE**
  - `cmd_ready`=1; a handshake latches base, count, fill and op.
  - count=0 goes to DONE.
  - LOAD goes to COLLECT; FILL goes to FILL.
- **COLLECT**
  - `in_ready`=1; each accepted chunk advances the chunk counter.
  - Acceptance of chunk `NCH-1` goes to WRITE.
- **WRITE**
  - `WE`=1, `ADDR_IN`=current address, `D_IN`=assembled entry; `in_ready`=0.
  - Address increments mod `depth`; the remaining count decrements.
  - If the remaining count reaches 0, go to DONE; otherwise return to COLLECT with the chunk counter and assembly register cleared.
- **FILL**
  - `WE`=1 every cycle with `D_IN`=`cmd_fill`; the address increments mod `depth`.
  - The last entry goes to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `WE` is 0 in every state other than WRITE and FILL. `ADDR_IN`/`D_IN` hold their last values when `WE`=0.
- `in_ready` is 0 outside COLLECT; chunks offered while IDLE are not consumed.
- Reset mid-command: return to IDLE and discard the partial entry. Entries already written remain in the register file. No write is issued in the reset cycle.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after it. `in_ready`, `WE`, `busy` and `done` are 0. `ADDR_IN` and `D_IN` are 0.
- Command handshake in cycle T:
  - FILL: `WE` is high in cycles T+1 … T+count, `done` in T+count+1, `cmd_ready` in T+count+2.
  - count=0: `done` in T+1, `cmd_ready` in T+2.
- LOAD: when the final chunk of an entry is accepted in cycle C, `WE` is high in C+1 and `in_ready` is high again in C+2 (if entries remain).
  - Peak rate is one entry per `NCH+1` cycles.
  - `in_valid` gaps only stall COLLECT.
- After the final write in cycle W: `done` in W+1, `cmd_ready` in W+2.
- Address wrap: `depth-1`+1 becomes 0, including when `depth` is not a power of two.

## Structure
- The shared package `regfile_loader_pkg` holds:
  - the op encodings `OP_LOAD`/`OP_FILL`;
  - the FSM state enumeration;
  - a constant function `nch(data_width, chunk_width)`.
- One sub-module, `regfile_chunk_packer`, owns:
  - the chunk counter and the `data_width` assembly register;
  - inputs: clear, accept, chunk;
  - outputs: entry, last-chunk flag.
- The FSM, address/count counters and output registers live in the top module.
- The top module connects directly to a `RegFile_16ports_load` write port.

## Test plan
All scenarios use `data_width`=20, `addr_width`=3, `chunk_width`=8, so `NCH`=3.
- **Wrapped LOAD**: LOAD base=6, count=3; chunks 45,23,F1 / 01,00,00 / FF,FF,0F → writes 0x12345@6, 0x00001@7, 0xFFFFF@0; `done` one cycle after the third `WE`.
- **FILL**: FILL base=5, count=8, fill=0xABCDE → `WE` on 8 consecutive cycles at addresses 5,6,7,0,1,2,3,4, then `done`, then `cmd_ready`.
- **Count edge cases**:
  - count=0 → no `WE`, `done` at T+1.
  - count=15 → saturates to 8 writes.
- **Backpressure**: random `in_valid` gaps (including 0 cycles and 10 cycles between chunks) → same write sequence; `in_ready`=0 during each WRITE cycle; no chunk lost or duplicated.
- **Reset mid-entry**: `RST` after chunk 2 of entry 2 → no further `WE`. The next LOAD base=0, count=1 with chunks 11,22,03 writes 0x32211@0, so no stale bits are present.
- **Idle and reset checks**: chunks offered while IDLE are not consumed (`in_ready`=0). All outputs read 0 during reset.

Source files
------------

// File: rtl/regfile_loader_pkg.sv
// Shared definitions for the register-file table loader: op codes, FSM states
// and the chunks-per-entry helper.
package regfile_loader_pkg;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_FILL = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_FILL,
        ST_DONE
    } state_t;

    function automatic int nch(input int data_width, input int chunk_width);
        return (data_width + chunk_width - 1) / chunk_width;
    endfunction

endpackage

// File: rtl/regfile_chunk_packer.sv
// Assembles LSB-first chunks into one data_width entry; bits of the last chunk
// beyond data_width are dropped.
module regfile_chunk_packer
    import regfile_loader_pkg::*;
#(
    parameter int data_width  = 1,
    parameter int chunk_width = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   clear,
    input  logic                   accept,
    input  logic [chunk_width-1:0] chunk,
    output logic [data_width-1:0]  entry,
    output logic                   last
);

    localparam int NCH   = nch(data_width, chunk_width);
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CNT_W-1:0]      cnt;
    logic [data_width-1:0] asm_q;
    logic [data_width-1:0] merged;
    logic                  unused_chunk;

    // Upper chunk bits are legitimately unused when data_width is not a chunk multiple.
    assign unused_chunk = ^chunk;

    // entry already includes the chunk being accepted, so the top can register it
    // in the same cycle the final chunk arrives.
    always_comb begin
        merged = asm_q;
        for (int i = 0; i < data_width; i++) begin
            if (accept && (cnt == CNT_W'(i / chunk_width))) begin
                merged[i] = chunk[i % chunk_width];
            end
        end
    end

    assign entry = merged;
    assign last  = (cnt == CNT_W'(NCH - 1));

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            cnt   <= '0;
            asm_q <= '0;
        end else if (accept) begin
            asm_q <= merged;
            cnt   <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_table_loader.sv
// Runtime loader that drives a LUT-RAM register file write port from LOAD
// (streamed chunks) or FILL (constant) commands.
module regfile_table_loader
    import regfile_loader_pkg::*;
#(
    parameter int data_width  = 1,
    parameter int addr_width  = 1,
    parameter int depth       = 1 << addr_width,
    parameter int chunk_width = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [addr_width-1:0]  cmd_base,
    input  logic [addr_width:0]    cmd_count,
    input  logic [data_width-1:0]  cmd_fill,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [chunk_width-1:0] in_data,
    output logic [addr_width-1:0]  ADDR_IN,
    output logic [data_width-1:0]  D_IN,
    output logic                   WE,
    output logic                   busy,
    output logic                   done,
    output state_t                 dbg_state
);

    localparam logic [addr_width:0]   DEPTH_N   = (addr_width + 1)'(depth);
    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(depth - 1);

    state_t                state;
    logic [addr_width-1:0] addr;
    logic [addr_width:0]   remaining;
    logic [addr_width:0]   count_sat;
    logic [data_width-1:0] fill_q;
    logic [addr_width-1:0] addr_q;
    logic [data_width-1:0] din_q;
    logic                  we_q;
    logic                  done_q;
    logic                  cmd_fire;
    logic                  chunk_fire;
    logic [data_width-1:0] entry;
    logic                  last_chunk;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; ready depends only on state (never on valid) and is low while RST is high.
    assign cmd_ready  = (state == ST_IDLE) && !RST;
    assign in_ready   = (state == ST_COLLECT) && !RST;
    assign busy       = (state != ST_IDLE) && !RST;
    assign WE         = we_q && !RST;
    assign done       = done_q && !RST;
    assign ADDR_IN    = addr_q;
    assign D_IN       = din_q;
    assign dbg_state  = state;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign chunk_fire = in_valid && in_ready;
    assign count_sat  = (cmd_count > DEPTH_N) ? DEPTH_N : cmd_count;

    // Explicit wrap so a non-power-of-two depth still returns to address 0.
    function automatic logic [addr_width-1:0] next_addr(input logic [addr_width-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    regfile_chunk_packer #(
        .data_width  (data_width),
        .chunk_width (chunk_width)
    ) u_packer (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (state != ST_COLLECT),
        .accept (chunk_fire),
        .chunk  (in_data),
        .entry  (entry),
        .last   (last_chunk)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            fill_q    <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        fill_q <= cmd_fill;
                        if (count_sat == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else if (cmd_op == OP_LOAD) begin
                            state     <= ST_COLLECT;
                            addr      <= cmd_base;
                            remaining <= count_sat;
                        end else begin
                            // First FILL write is issued straight from the command.
                            state     <= ST_FILL;
                            we_q      <= 1'b1;
                            addr_q    <= cmd_base;
                            din_q     <= cmd_fill;
                            addr      <= next_addr(cmd_base);
                            remaining <= count_sat - 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (chunk_fire && last_chunk) begin
                        state     <= ST_WRITE;
                        we_q      <= 1'b1;
                        addr_q    <= addr;
                        din_q     <= entry;
                        addr      <= next_addr(addr);
                        remaining <= remaining - 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (remaining == '0) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= ST_COLLECT;
                    end
                end
                ST_FILL: begin
                    if (remaining == '0) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        we_q      <= 1'b1;
                        addr_q    <= addr;
                        din_q     <= fill_q;
                        addr      <= next_addr(addr);
                        remaining <= remaining - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_table_loader.sv
// Randomized bench for regfile_table_loader: write stream checked against an
// address/data list computed from command and chunk values.
module tb_regfile_table_loader;
    import regfile_loader_pkg::*;

    localparam int DW    = 20;
    localparam int AW    = 3;
    localparam int CW    = 8;
    localparam int DEPTH = 8;
    localparam int W     = AW + DW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0]   cmd_count = '0;
    logic [DW-1:0] cmd_fill = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_data = '0;
    logic [AW-1:0] ADDR_IN;
    logic [DW-1:0] D_IN;
    logic          WE;
    logic          busy;
    logic          done;
    state_t        dbg_state;

    regfile_table_loader #(
        .data_width  (DW),
        .addr_width  (AW),
        .depth       (DEPTH),
        .chunk_width (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_base  (cmd_base),
        .cmd_count (cmd_count),
        .cmd_fill  (cmd_fill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ADDR_IN   (ADDR_IN),
        .D_IN      (D_IN),
        .WE        (WE),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   chunk_q[$];
    int we_cnt      = 0;
    int last_we_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] wr(input int a, input int d);
        return {AW'(a % DEPTH), DW'(d)};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            logic [W-1:0] e;
            we_cnt++;
            last_we_cyc = cyc;
            check("in_ready_during_write", in_ready, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {ADDR_IN, D_IN}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr_data", {ADDR_IN, D_IN}, e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input int base, input int count,
                            input int fill, output int t);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = AW'(base);
        cmd_count = (AW + 1)'(count);
        cmd_fill  = DW'(fill);
        t = cyc;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_base  = AW'($urandom);
        cmd_count = (AW + 1)'($urandom);
        cmd_fill  = DW'($urandom);
    endtask

    task automatic push_chunk(input logic [7:0] d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (!in_ready) check("chunk_timeout", 0, 1);
        step();
        in_valid = 1'b0;
        in_data  = CW'($urandom);
    endtask

    task automatic wait_done(output int dc);
        int guard = 0;
        while (done !== 1'b1 && guard < 300) begin
            step();
            guard++;
        end
        if (done !== 1'b1) check("done_timeout", 0, 1);
        dc = cyc;
    endtask

    function automatic int sat(input int count);
        return (count > DEPTH) ? DEPTH : count;
    endfunction

    // LOAD: entries come from chunk_q, three bytes per entry, LSB first.
    task automatic run_load(input int base, input int count, input int gap_mode);
        int n, t, dc, we0, gap;
        n   = sat(count);
        we0 = we_cnt;
        for (int i = 0; i < n; i++) begin
            int d;
            d = int'(chunk_q[3*i]) | (int'(chunk_q[3*i+1]) << 8) | (int'(chunk_q[3*i+2]) << 16);
            exp_q.push_back(wr(base + i, d));
        end
        send_cmd(OP_LOAD, base, count, int'($urandom), t);
        check("busy_after_load_cmd", busy, 1);
        for (int i = 0; i < 3 * n; i++) begin
            case (gap_mode)
                0: gap = 0;
                1: gap = 10;
                2: gap = $urandom_range(0, 3);
                default: gap = ($urandom_range(0, 2) == 0) ? 10 : $urandom_range(0, 2);
            endcase
            repeat (gap) step();
            push_chunk(chunk_q[i]);
        end
        wait_done(dc);
        check("load_write_count", we_cnt - we0, n);
        if (n > 0) check("load_done_after_last_we", dc - last_we_cyc, 1);
        else       check("load_zero_done_latency", dc - t, 1);
        step();
        check("cmd_ready_after_load", cmd_ready, 1);
        chunk_q.delete();
    endtask

    task automatic run_fill(input logic [1:0] op, input int base, input int count, input int fill);
        int n, t, dc, we0;
        n   = sat(count);
        we0 = we_cnt;
        for (int i = 0; i < n; i++) exp_q.push_back(wr(base + i, fill));
        send_cmd(op, base, count, fill, t);
        check("busy_after_fill_cmd", busy, 1);
        wait_done(dc);
        check("fill_write_count", we_cnt - we0, n);
        if (n > 0) check("fill_last_we_cycle", last_we_cyc - t, n);
        check("fill_done_cycle", dc - t, n + 1);
        step();
        check("cmd_ready_after_fill", cmd_ready, 1);
    endtask

    task automatic random_chunks(input int n);
        for (int i = 0; i < 3 * n; i++) chunk_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", WE, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr_in", ADDR_IN, 0);
        check("rst_d_in", D_IN, 0);
        RST = 1'b0;
        #1;
        check("cmd_ready_after_rst", cmd_ready, 1);

        // Chunks offered while idle must not be consumed.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (4) begin
            step();
            check("idle_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        // Wrapped LOAD: 0x12345@6, 0x00001@7, 0xFFFFF@0.
        chunk_q = '{8'h45, 8'h23, 8'hF1, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h0F};
        run_load(6, 3, 0);

        run_fill(OP_FILL, 5, 8, 20'hABCDE);
        check("addr_hold_after_fill", ADDR_IN, 4);
        check("data_hold_after_fill", D_IN, 20'hABCDE);

        run_fill(OP_FILL, 3, 0, 20'h12345);
        run_load(2, 0, 0);
        run_fill(2'd3, $urandom_range(0, 7), 15, int'($urandom));

        for (int k = 0; k < 8; k++) begin
            int base, count;
            base  = $urandom_range(0, 7);
            count = $urandom_range(1, 9);
            random_chunks(sat(count));
            run_load(base, count, k % 4);
        end
        for (int k = 0; k < 4; k++) begin
            run_fill(2'($urandom_range(1, 3)), $urandom_range(0, 7), $urandom_range(1, 15),
                     int'($urandom));
        end

        // Reset after chunk 2 of entry 2: only entry 1 is written.
        exp_q.push_back(wr(2, 32'h0C_BBAA));
        send_cmd(OP_LOAD, 2, 3, 0, t0);
        push_chunk(8'hAA);
        push_chunk(8'hBB);
        push_chunk(8'hFC);
        push_chunk(8'h77);
        push_chunk(8'h88);
        RST = 1'b1;
        step();
        check("mid_rst_we", WE, 0);
        check("mid_rst_busy", busy, 0);
        step();
        RST = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h99;
        repeat (10) begin
            step();
            check("post_rst_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        chunk_q = '{8'h11, 8'h22, 8'h03};
        run_load(0, 1, 0);

        repeat (5) step();
        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
